// File: rtl/pd_pwm_controller.sv
// Proportional-derivative distance controller: latches sensor samples, computes a saturated
// control value, divides it into a duty step and drives a period-aligned, glitch-free PWM.
module pd_pwm_controller #(
    parameter int DIST_W         = 32,
    parameter int THRESH         = 1999999,
    parameter int KP             = 1,
    parameter int KD             = 0,
    parameter int STEP_SIZE      = 85714,
    parameter int STEPS          = 20,
    parameter int TICKS_PER_STEP = 1000,
    parameter int TIMEOUT_CYC    = 10000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIST_W-1:0]          DISTANCE,
    input  logic                       DISTANCE_VALID,
    output logic                       PWM,
    output logic [$clog2(STEPS+1)-1:0] DUTY_STEP,
    output logic [6:0]                 DUTY_PCT,
    output logic                       BUSY,
    output logic                       STALE
);

    localparam int CW  = DIST_W + 16;
    localparam int SW  = $clog2(STEPS + 1);
    localparam int TW  = $clog2(TICKS_PER_STEP + 1);
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    localparam int DCW = $clog2(CW + 1);

    localparam logic [DIST_W-1:0]    THRESH_V  = DIST_W'(THRESH);
    localparam logic [DIST_W-1:0]    THRESH_P1 = DIST_W'(THRESH + 1);
    localparam logic signed [CW-1:0] KP_C      = CW'(KP);
    localparam logic signed [CW-1:0] KD_C      = CW'(KD);
    localparam logic [CW-1:0]        CTRL_MAX  = CW'(STEPS * STEP_SIZE);
    localparam logic [CW:0]          STEP_C    = (CW + 1)'(STEP_SIZE);
    localparam logic [CW-1:0]        STEPS_Q   = CW'(STEPS);
    localparam logic [SW-1:0]        STEPS_D   = SW'(STEPS);
    localparam logic [SW-1:0]        STEP_MAX  = SW'(STEPS - 1);
    localparam logic [TW-1:0]        TICK_MAX  = TW'(TICKS_PER_STEP - 1);
    localparam logic [TOW-1:0]       TO_LAST   = TOW'(TIMEOUT_CYC - 1);
    localparam logic [DCW-1:0]       DIV_LAST  = DCW'(CW - 1);
    localparam logic [6:0]           PCT_STEP  = 7'(100 / STEPS);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_DONE} state_t;

    state_t                state;
    logic [DIST_W-1:0]     dist_reg;
    logic [DIST_W-1:0]     e_prev;
    logic                  first;
    logic                  pending;
    logic [CW-1:0]         quo;
    logic [CW-1:0]         rem;
    logic [DCW-1:0]        div_cnt;
    logic [SW-1:0]         duty_pending;
    logic [TOW-1:0]        to_cnt;

    logic [DIST_W-1:0]        e_cur;
    logic signed [DIST_W:0]   delta;
    logic signed [CW-1:0]     e_ext;
    logic signed [CW-1:0]     delta_ext;
    logic signed [CW-1:0]     ctrl_raw;
    logic [CW-1:0]            ctrl_sat;
    logic [CW:0]              rem_shift;
    logic [CW-1:0]            rem_next;
    logic                     q_bit;

    always_comb begin
        e_cur     = (dist_reg > THRESH_V) ? '0 : THRESH_V - dist_reg;
        delta     = first ? '0 : $signed({1'b0, e_cur}) - $signed({1'b0, e_prev});
        e_ext     = $signed({{(CW - DIST_W){1'b0}}, e_cur});
        delta_ext = $signed({{(CW - DIST_W - 1){delta[DIST_W]}}, delta});
        ctrl_raw  = KP_C * e_ext + KD_C * delta_ext;
        if (ctrl_raw[CW-1])
            ctrl_sat = '0;
        else if ($unsigned(ctrl_raw) > CTRL_MAX)
            ctrl_sat = CTRL_MAX;
        else
            ctrl_sat = $unsigned(ctrl_raw);
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem, quo[CW-1]};
        if (rem_shift >= STEP_C) begin
            rem_next = CW'(rem_shift - STEP_C);
            q_bit    = 1'b1;
        end else begin
            rem_next = rem_shift[CW-1:0];
            q_bit    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            dist_reg     <= THRESH_V;
            e_prev       <= '0;
            first        <= 1'b1;
            pending      <= 1'b0;
            quo          <= '0;
            rem          <= '0;
            div_cnt      <= '0;
            duty_pending <= '0;
            to_cnt       <= '0;
            BUSY         <= 1'b0;
            STALE        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        state   <= S_CALC;
                        pending <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end
                S_CALC: begin
                    quo     <= ctrl_sat;
                    rem     <= '0;
                    div_cnt <= '0;
                    e_prev  <= e_cur;
                    // A timed-out sample keeps the derivative disarmed for the next real sample.
                    first   <= STALE;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    quo     <= {quo[CW-2:0], q_bit};
                    rem     <= rem_next;
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == DIV_LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    duty_pending <= (quo > STEPS_Q) ? STEPS_D : quo[SW-1:0];
                    if (pending) begin
                        state   <= S_CALC;
                        pending <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed after the FSM so a new sample or timeout wins over pending/first updates above.
            if (DISTANCE_VALID) begin
                dist_reg <= DISTANCE;
                pending  <= 1'b1;
                to_cnt   <= '0;
                STALE    <= 1'b0;
            end else if (!STALE) begin
                if (to_cnt == TO_LAST) begin
                    STALE    <= 1'b1;
                    dist_reg <= THRESH_P1;
                    first    <= 1'b1;
                    pending  <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TOW'(1);
                end
            end
        end
    end

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] step_cnt;
    logic          tick_wrap;
    logic          period_end;
    logic [SW-1:0] step_next;
    logic [SW-1:0] duty_next;
    logic [6:0]    pct_next;

    always_comb begin
        tick_wrap  = (tick_cnt == TICK_MAX);
        period_end = tick_wrap && (step_cnt == STEP_MAX);
        if (!tick_wrap)
            step_next = step_cnt;
        else if (step_cnt == STEP_MAX)
            step_next = '0;
        else
            step_next = step_cnt + SW'(1);
        duty_next = period_end ? duty_pending : DUTY_STEP;
        pct_next  = 7'(duty_pending) * PCT_STEP;
    end

    // PWM is computed from the next counter/duty values so it lines up with the period it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            step_cnt  <= '0;
            PWM       <= 1'b0;
            DUTY_STEP <= '0;
            DUTY_PCT  <= '0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            step_cnt <= step_next;
            PWM      <= (step_next < duty_next);
            if (period_end) begin
                DUTY_STEP <= duty_pending;
                DUTY_PCT  <= pct_next;
            end
        end
    end

endmodule

// File: tb/tb_pd_pwm_controller.sv
// Randomised, self-checking bench for pd_pwm_controller against an arithmetic reference model.
module tb_pd_pwm_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dist_a, dist_b, dist_c;
    logic        valid_a, valid_b, valid_c;
    logic        pwm_a, pwm_b, pwm_c;
    logic [4:0]  duty_a, duty_b, duty_c;
    logic [6:0]  pct_a, pct_b, pct_c;
    logic        busy_a, busy_b, busy_c;
    logic        stale_a, stale_b, stale_c;

    int checks = 0;
    int passed = 0;

    longint m_eprev;
    bit     m_first;

    always #5 clk = ~clk;

    pd_pwm_controller #(.KP(1), .KD(0), .TICKS_PER_STEP(2), .TIMEOUT_CYC(1000000)) dut_a (
        .clk(clk), .rst(rst), .DISTANCE(dist_a), .DISTANCE_VALID(valid_a), .PWM(pwm_a),
        .DUTY_STEP(duty_a), .DUTY_PCT(pct_a), .BUSY(busy_a), .STALE(stale_a));

    pd_pwm_controller #(.KP(1), .KD(2), .TICKS_PER_STEP(2), .TIMEOUT_CYC(1000000)) dut_b (
        .clk(clk), .rst(rst), .DISTANCE(dist_b), .DISTANCE_VALID(valid_b), .PWM(pwm_b),
        .DUTY_STEP(duty_b), .DUTY_PCT(pct_b), .BUSY(busy_b), .STALE(stale_b));

    pd_pwm_controller #(.KP(1), .KD(2), .TICKS_PER_STEP(2), .TIMEOUT_CYC(100)) dut_c (
        .clk(clk), .rst(rst), .DISTANCE(dist_c), .DISTANCE_VALID(valid_c), .PWM(pwm_c),
        .DUTY_STEP(duty_c), .DUTY_PCT(pct_c), .BUSY(busy_c), .STALE(stale_c));

    // Reference: error, derivative, saturation and floor division straight from the control law.
    function automatic int model_q(input longint d, input longint kd);
        longint e, delta, ctrl, q;
        e     = (d > 1999999) ? 0 : 1999999 - d;
        delta = m_first ? 0 : e - m_eprev;
        ctrl  = e + kd * delta;
        if (ctrl < 0) ctrl = 0;
        if (ctrl > 20 * 85714) ctrl = 20 * 85714;
        q = ctrl / 85714;
        if (q > 20) q = 20;
        m_eprev = e;
        m_first = 1'b0;
        return int'(q);
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int which, input logic [31:0] d);
        case (which)
            0: begin dist_a = d; valid_a = 1'b1; end
            1: begin dist_b = d; valid_b = 1'b1; end
            default: begin dist_c = d; valid_c = 1'b1; end
        endcase
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    task automatic countPwm(input int which, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            case (which)
                0: hi += int'(pwm_a);
                1: hi += int'(pwm_b);
                default: hi += int'(pwm_c);
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        waitCycles(3);
        checks++; if (duty_a !== 5'd0) $display("[TB] FAIL reset_duty_a: got %0d expected 0", duty_a); else passed++;
        checks++; if (pct_a !== 7'd0) $display("[TB] FAIL reset_pct_a: got %0d expected 0", pct_a); else passed++;
        checks++; if (pwm_a !== 1'b0) $display("[TB] FAIL reset_pwm_a: got %0d expected 0", pwm_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("[TB] FAIL reset_busy_a: got %0d expected 0", busy_a); else passed++;
        checks++; if (stale_c !== 1'b0) $display("[TB] FAIL reset_stale_c: got %0d expected 0", stale_c); else passed++;
        rst = 1'b0;
        waitCycles(1);
    endtask

    task automatic test_p_only;
        int hi;
        applyStimulus(0, 32'd1000000);
        waitCycles(50);
        checks++; if (duty_a !== 5'd0) $display("[TB] FAIL p_only_early: got %0d expected 0", duty_a); else passed++;
        waitCycles(44);
        checks++; if (duty_a !== 5'd11) $display("[TB] FAIL p_only_duty: got %0d expected 11", duty_a); else passed++;
        checks++; if (pct_a !== 7'd55) $display("[TB] FAIL p_only_pct: got %0d expected 55", pct_a); else passed++;
        countPwm(0, 40, hi);
        checks++; if (hi != 22) $display("[TB] FAIL p_only_pwm_high: got %0d expected 22", hi); else passed++;
    endtask

    task automatic test_mid_period;
        int  hi [3];
        bit  found;
        logic prev;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            prev = pwm_a;
            @(negedge clk);
            if (prev === 1'b0 && pwm_a === 1'b1) found = 1'b1;
        end
        checks++; if (!found) $display("[TB] FAIL mid_align: got no period start, expected one within 100 cycles"); else passed++;
        hi = '{0, 0, 0};
        for (int i = 0; i < 120; i++) begin
            if (i == 10) begin dist_a = 32'd0; valid_a = 1'b1; end
            if (i == 11) valid_a = 1'b0;
            if (i == 79) begin
                checks++; if (duty_a !== 5'd11) $display("[TB] FAIL mid_hold_duty: got %0d expected 11", duty_a); else passed++;
            end
            hi[i / 40] += int'(pwm_a);
            @(negedge clk);
        end
        checks++; if (hi[0] != 22) $display("[TB] FAIL mid_period0: got %0d expected 22", hi[0]); else passed++;
        checks++; if (hi[1] != 22) $display("[TB] FAIL mid_period1: got %0d expected 22", hi[1]); else passed++;
        checks++; if (hi[2] != 40) $display("[TB] FAIL mid_period2: got %0d expected 40", hi[2]); else passed++;
        checks++; if (pct_a !== 7'd100) $display("[TB] FAIL mid_pct: got %0d expected 100", pct_a); else passed++;
    endtask

    task automatic test_saturation;
        int hi;
        applyStimulus(0, 32'd2500000);
        waitCycles(94);
        checks++; if (duty_a !== 5'd0) $display("[TB] FAIL far_duty: got %0d expected 0", duty_a); else passed++;
        countPwm(0, 40, hi);
        checks++; if (hi != 0) $display("[TB] FAIL far_pwm_high: got %0d expected 0", hi); else passed++;
        applyStimulus(0, 32'd0);
        waitCycles(94);
        checks++; if (duty_a !== 5'd20) $display("[TB] FAIL near_duty: got %0d expected 20", duty_a); else passed++;
        checks++; if (pct_a !== 7'd100) $display("[TB] FAIL near_pct: got %0d expected 100", pct_a); else passed++;
        countPwm(0, 40, hi);
        checks++; if (hi != 40) $display("[TB] FAIL near_pwm_high: got %0d expected 40", hi); else passed++;
    endtask

    task automatic test_kd_sequence;
        int dists [3] = '{1000000, 900000, 1000000};
        int exps  [3] = '{11, 15, 9};
        m_first = 1'b1;
        m_eprev = 0;
        for (int i = 0; i < 3; i++) begin
            void'(model_q(longint'(dists[i]), 2));
            applyStimulus(1, 32'(dists[i]));
            waitCycles(94);
            checks++; if (int'(duty_b) != exps[i]) $display("[TB] FAIL kd_seq%0d_duty: got %0d expected %0d", i, duty_b, exps[i]); else passed++;
            checks++; if (int'(pct_b) != exps[i] * 5) $display("[TB] FAIL kd_seq%0d_pct: got %0d expected %0d", i, pct_b, exps[i] * 5); else passed++;
        end
    endtask

    task automatic test_random;
        int d, exp_q, hi;
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(2600000, 0));
            exp_q = model_q(longint'(d), 2);
            applyStimulus(1, 32'(d));
            waitCycles(94);
            checks++; if (int'(duty_b) != exp_q) $display("[TB] FAIL rand%0d_duty d=%0d: got %0d expected %0d", i, d, duty_b, exp_q); else passed++;
            checks++; if (int'(pct_b) != exp_q * 5) $display("[TB] FAIL rand%0d_pct: got %0d expected %0d", i, pct_b, exp_q * 5); else passed++;
            countPwm(1, 40, hi);
            checks++; if (hi != 2 * exp_q) $display("[TB] FAIL rand%0d_pwm_high: got %0d expected %0d", i, hi, 2 * exp_q); else passed++;
        end
    endtask

    task automatic test_timeout;
        applyStimulus(2, 32'd1000000);
        waitCycles(94);
        checks++; if (duty_c !== 5'd11) $display("[TB] FAIL to_first_duty: got %0d expected 11", duty_c); else passed++;
        waitCycles(4);
        checks++; if (stale_c !== 1'b0) $display("[TB] FAIL to_not_yet: got %0d expected 0", stale_c); else passed++;
        waitCycles(4);
        checks++; if (stale_c !== 1'b1) $display("[TB] FAIL to_stale: got %0d expected 1", stale_c); else passed++;
        checks++; if (duty_c !== 5'd11) $display("[TB] FAIL to_hold_duty: got %0d expected 11", duty_c); else passed++;
        waitCycles(97);
        checks++; if (duty_c !== 5'd0) $display("[TB] FAIL to_zero_duty: got %0d expected 0", duty_c); else passed++;
        checks++; if (stale_c !== 1'b1) $display("[TB] FAIL to_stale_hold: got %0d expected 1", stale_c); else passed++;
        applyStimulus(2, 32'd900000);
        checks++; if (stale_c !== 1'b0) $display("[TB] FAIL to_clear: got %0d expected 0", stale_c); else passed++;
        waitCycles(94);
        checks++; if (duty_c !== 5'd12) $display("[TB] FAIL to_delta0_duty: got %0d expected 12", duty_c); else passed++;
        checks++; if (pct_c !== 7'd60) $display("[TB] FAIL to_delta0_pct: got %0d expected 60", pct_c); else passed++;
    endtask

    task automatic test_back_to_back;
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i <= 110; i++) begin
            if (i == 0) begin dist_a = 32'd500000; valid_a = 1'b1; end
            if (i == 1) valid_a = 1'b0;
            if (i == 2) begin dist_a = 32'd1500000; valid_a = 1'b1; end
            if (i == 3) valid_a = 1'b0;
            busy_cnt += int'(busy_a);
            @(negedge clk);
        end
        checks++; if (busy_cnt != 100) $display("[TB] FAIL b2b_busy_cycles: got %0d expected 100", busy_cnt); else passed++;
        waitCycles(40);
        checks++; if (duty_a !== 5'd5) $display("[TB] FAIL b2b_duty: got %0d expected 5", duty_a); else passed++;
        checks++; if (pct_a !== 7'd25) $display("[TB] FAIL b2b_pct: got %0d expected 25", pct_a); else passed++;
    endtask

    task automatic test_reset_during_div;
        applyStimulus(0, 32'd0);
        waitCycles(9);
        checks++; if (busy_a !== 1'b1) $display("[TB] FAIL rdiv_busy_before: got %0d expected 1", busy_a); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (duty_a !== 5'd0) $display("[TB] FAIL rdiv_duty: got %0d expected 0", duty_a); else passed++;
        checks++; if (pct_a !== 7'd0) $display("[TB] FAIL rdiv_pct: got %0d expected 0", pct_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("[TB] FAIL rdiv_busy: got %0d expected 0", busy_a); else passed++;
        checks++; if (pwm_a !== 1'b0) $display("[TB] FAIL rdiv_pwm: got %0d expected 0", pwm_a); else passed++;
        rst = 1'b0;
        waitCycles(120);
        checks++; if (duty_a !== 5'd0) $display("[TB] FAIL rdiv_no_resume: got %0d expected 0", duty_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("[TB] FAIL rdiv_idle: got %0d expected 0", busy_a); else passed++;
    endtask

    initial begin
        rst     = 1'b1;
        dist_a  = '0; dist_b = '0; dist_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        test_reset;
        test_p_only;
        test_mid_period;
        test_saturation;
        test_kd_sequence;
        test_random;
        test_timeout;
        test_back_to_back;
        test_reset_during_div;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pd_pwm_controller.md
Name: pd_pwm_controller

Overview:
Parametrised successor to the single-channel P-only distance-to-PWM controller. Latches ultrasonic distance samples and computes a saturated proportional-derivative control value per sample. Quantises that value into a duty step with a sequential divider and drives a glitch-free PWM output. Adds a D term, a stale-sample timeout, and period-aligned duty updates; sits between the distance sensor front end and the motor/buzzer driver.

Parameters:
DIST_W, 32, distance/error width (unsigned)
THRESH, 1999999, error = THRESH - distance; distances above THRESH give error 0
KP, 1, proportional gain (non-negative integer)
KD, 0, derivative gain (non-negative integer)
STEP_SIZE, 85714, control units per duty step
STEPS, 20, number of duty steps at 100%; must divide 100
TICKS_PER_STEP, 1000, clk cycles per PWM step; PWM period = STEPS*TICKS_PER_STEP
TIMEOUT_CYC, 10000000, cycles without DISTANCE_VALID before the sample is declared stale

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
DISTANCE  in  DIST_W  distance sample
DISTANCE_VALID  in  1  single-cycle strobe qualifying DISTANCE
PWM  out  1  PWM output
DUTY_STEP  out  $clog2(STEPS+1)  duty step applied in the current PWM period
DUTY_PCT  out  7  DUTY_STEP*(100/STEPS), registered
BUSY  out  1  high while a control computation is in progress
STALE  out  1  high while the timeout is active

Behaviour:
- Reset (clk, rst synchronous, active-high): dist_reg=THRESH, e_prev=0, first=1, FSM=IDLE, pending=0, duty_pending=0, DUTY_STEP=0, DUTY_PCT=0, PWM=0, BUSY=0, STALE=0, PWM counters=0, timeout counter=0. Reset overrides every other event, including a division in progress.
- Sample capture: DISTANCE_VALID in any state → dist_reg<=DISTANCE, pending<=1, timeout counter cleared, STALE<=0. If several samples arrive while BUSY, only the last is kept.
- Timeout: the counter increments every cycle without a valid sample. On reaching TIMEOUT_CYC-1: STALE<=1, dist_reg<=THRESH+1 (error 0), first<=1, pending<=1. Fires once and holds until the next valid sample.
- FSM IDLE→CALC when pending=1 (pending cleared on entry).
- CALC, 1 cycle:
  - e = (dist_reg>THRESH) ? 0 : THRESH-dist_reg, unsigned DIST_W.
  - delta = first ? 0 : e - e_prev, signed DIST_W+1.
  - ctrl = KP*e + KD*delta in signed DIST_W+16 bits.
  - Saturate ctrl to [0, STEPS*STEP_SIZE].
  - e_prev<=e, first<=0.
- DIV: restoring divider, one quotient bit per cycle, exactly DIST_W+16 cycles. q = ctrl/STEP_SIZE (floor), then clamped to STEPS.
- DONE, 1 cycle: duty_pending<=q, then →IDLE, or →CALC if pending was set meanwhile.
- BUSY=1 in CALC/DIV/DONE.
- PWM generation:
  - tick counter 0..TICKS_PER_STEP-1; step counter 0..STEPS-1 advances when tick wraps.
  - PWM registered, high iff step_cnt < DUTY_STEP.
  - DUTY_STEP and DUTY_PCT load duty_pending only at period start (step_cnt=0, tick=0), so there are no partial pulses. Duty 0 gives constant low; duty STEPS gives constant high.
- Latency: a valid sample at cycle t gives duty_pending updated at t+DIST_W+19; it is applied at the next period boundary.

Test Plan:
- KP=1, KD=0, DISTANCE=1000000 → e=999999, ctrl=999999, DUTY_STEP=11, DUTY_PCT=55 after the next period boundary.
- DISTANCE=2500000 → DUTY_STEP=0, PWM constant low. DISTANCE=0 → ctrl saturates at 1714280, DUTY_STEP=20, DUTY_PCT=100, PWM constant high.
- KP=1, KD=2, sample sequence:
  - 1000000 → DUTY_STEP 11 (first sample, delta 0).
  - 900000 → ctrl=1299999 → DUTY_STEP 15 (75%).
  - 1000000 → ctrl=799999 → DUTY_STEP 9 (45%).
- TICKS_PER_STEP=2, STEPS=20, duty 11 → PWM high exactly 22 of every 40 clocks. A new duty computed mid-period leaves the current period unchanged and is applied at the next step_cnt=0.
- TIMEOUT_CYC=100, one sample of 0 then no samples → STALE=1 at cycle 100 after the sample, DUTY_STEP→0 at the following boundary. A new valid sample clears STALE and recomputes with delta 0.
- Back-to-back samples while BUSY: samples 500000 and 1500000 two cycles apart → exactly one extra computation. Final DUTY_STEP=5 (ctrl=499999). Asserting rst during DIV → all outputs return to reset values the next cycle.
